// File: rtl/dmem_timer_resp.sv
// dmem_timer_resp: data RAM with byte-lane writes plus a memory-mapped 64-bit machine timer.
// Define DMEM_BUSERR_EN to enable the sticky bus-error flag for unmapped or misaligned accesses.
module dmem_timer_resp #(
  parameter int unsigned RAM_AW     = 12,
  parameter logic [31:0] TIMER_BASE = 32'h4000_0000,
  parameter int unsigned PRESCALE   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_ce_i,
  input  logic        ram_we_i,
  input  logic [31:0] ram_addr_i,
  input  logic [3:0]  ram_sel_i,
  input  logic [31:0] ram_data_i,
  output logic [31:0] ram_data_o,
  output logic        timer_irq_o,
  output logic        bus_err_o
);
  localparam int unsigned RAM_WORDS = 2**RAM_AW;
  localparam logic [15:0] PSC_LAST  = 16'(PRESCALE - 1);

  logic [31:0] r_mem [RAM_WORDS];
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_en;
  logic [15:0] r_psc;

  logic              w_ram_hit;
  logic              w_tmr_reg;
  logic              w_bad;
  logic              w_wr;
  logic              w_tmr_wr;
  logic              w_ctrl_wr;
  logic              w_tick;
  logic [2:0]        w_toff;
  logic [RAM_AW-1:0] w_widx;
  logic [63:0]       w_mtime_nxt;
  logic [31:0]       w_tmr_rdata;
  logic              w_unused;

  assign w_ram_hit = (ram_addr_i[31:RAM_AW+2] == '0);
  assign w_toff    = ram_addr_i[4:2];
  assign w_tmr_reg = (ram_addr_i[31:5] == TIMER_BASE[31:5]) && (w_toff <= 3'd4);
  assign w_widx    = ram_addr_i[RAM_AW+1:2];
  assign w_unused  = ^ram_addr_i[1:0];

`ifdef DMEM_BUSERR_EN
  assign w_bad = !(w_ram_hit || w_tmr_reg) || (ram_addr_i[1:0] != 2'b00);
`else
  assign w_bad = !(w_ram_hit || w_tmr_reg);
`endif

  // A write coinciding with reset is discarded, including RAM writes.
  assign w_wr      = ram_ce_i && ram_we_i && !w_bad && !rst;
  assign w_tmr_wr  = w_wr && !w_ram_hit && (ram_sel_i == 4'hF);
  assign w_ctrl_wr = w_tmr_wr && (w_toff == 3'd4);
  assign w_tick    = r_en && (r_psc == PSC_LAST);

  // The half being written takes bus data; the other half keeps the incremented value.
  always_comb begin
    w_mtime_nxt = w_tick ? (r_mtime + 64'd1) : r_mtime;
    if (w_tmr_wr && (w_toff == 3'd0)) w_mtime_nxt[31:0]  = ram_data_i;
    if (w_tmr_wr && (w_toff == 3'd1)) w_mtime_nxt[63:32] = ram_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_en       <= 1'b0;
      r_psc      <= '0;
    end else begin
      r_mtime <= w_mtime_nxt;
      if (w_tmr_wr && (w_toff == 3'd2)) r_mtimecmp[31:0]  <= ram_data_i;
      if (w_tmr_wr && (w_toff == 3'd3)) r_mtimecmp[63:32] <= ram_data_i;
      if (w_ctrl_wr) r_en <= ram_data_i[0];
      if (w_ctrl_wr || !r_en || w_tick) r_psc <= '0;
      else                              r_psc <= r_psc + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && w_ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_sel_i[i]) r_mem[w_widx][8*i +: 8] <= ram_data_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_tmr_rdata = '0;
    case (w_toff)
      3'd0:    w_tmr_rdata = r_mtime[31:0];
      3'd1:    w_tmr_rdata = r_mtime[63:32];
      3'd2:    w_tmr_rdata = r_mtimecmp[31:0];
      3'd3:    w_tmr_rdata = r_mtimecmp[63:32];
      3'd4:    w_tmr_rdata = {31'b0, r_en};
      default: w_tmr_rdata = '0;
    endcase
  end

  always_comb begin
    ram_data_o = '0;
    if (ram_ce_i && !ram_we_i && !w_bad && !rst)
      ram_data_o = w_ram_hit ? r_mem[w_widx] : w_tmr_rdata;
  end

  assign timer_irq_o = r_en && (r_mtime >= r_mtimecmp);

`ifdef DMEM_BUSERR_EN
  logic r_bus_err;

  always_ff @(posedge clk) begin
    if (rst)                     r_bus_err <= 1'b0;
    else if (ram_ce_i && w_bad)  r_bus_err <= 1'b1;
  end

  assign bus_err_o = r_bus_err;
`else
  assign bus_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_timer_resp.sv
// Scoreboard bench for dmem_timer_resp: two instances (PRESCALE 1 and 4) share one bus.
// Expectations follow DMEM_BUSERR_EN when the bench is built with it.
module tb_dmem_timer_resp;
   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  sel;
   logic [31:0] wdata;
   logic [31:0] rdata1, rdata4;
   logic        irq1, irq4, err1, err4;

   localparam logic [31:0] T_MLO  = 32'h4000_0000;
   localparam logic [31:0] T_MHI  = 32'h4000_0004;
   localparam logic [31:0] T_CLO  = 32'h4000_0008;
   localparam logic [31:0] T_CHI  = 32'h4000_000C;
   localparam logic [31:0] T_CTRL = 32'h4000_0010;
`ifdef DMEM_BUSERR_EN
   localparam logic [31:0] EXP_ERR = 32'd1;
   localparam logic [31:0] EXP_MIS = 32'd0;
`else
   localparam logic [31:0] EXP_ERR = 32'd0;
   localparam logic [31:0] EXP_MIS = 32'h11BB_33DD;
`endif

   always #5 clk = ~clk;

   dmem_timer_resp #(.PRESCALE(1)) u_dut1 (
      .clk(clk), .rst(rst), .ram_ce_i(ce), .ram_we_i(we), .ram_addr_i(addr),
      .ram_sel_i(sel), .ram_data_i(wdata), .ram_data_o(rdata1),
      .timer_irq_o(irq1), .bus_err_o(err1)
   );

   dmem_timer_resp #(.PRESCALE(4)) u_dut4 (
      .clk(clk), .rst(rst), .ram_ce_i(ce), .ram_we_i(we), .ram_addr_i(addr),
      .ram_sel_i(sel), .ram_data_i(wdata), .ram_data_o(rdata4),
      .timer_irq_o(irq4), .bus_err_o(err4)
   );

   // kind: 0 = read data, 1 = irq, 2 = bus error
   typedef struct {
      int          dut;
      int          kind;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_err = 0;

   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] act;
      while (q.size() > 0) begin
         e = q.pop_front();
         case (e.kind)
            0:       act = (e.dut == 4) ? rdata4 : rdata1;
            1:       act = {31'b0, (e.dut == 4) ? irq4 : irq1};
            default: act = {31'b0, (e.dut == 4) ? err4 : err1};
         endcase
         n_chk++;
         if (act !== e.val) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.val);
         end
      end
   end

   task automatic check_now(input logic [31:0] act, input logic [31:0] exp_v, input string name);
      n_chk++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   initial begin
      #200000;
      n_err++;
      $display("FAIL timeout: sequence did not complete");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   task automatic expect_v(input int dut, input int kind, input logic [31:0] val, input string name);
      exp_t e;
      e.dut = dut; e.kind = kind; e.val = val; e.name = name;
      q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      ce = 1'b0; we = 1'b0; sel = 4'h0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      ce = 1'b1; we = 1'b1; addr = a; wdata = d; sel = s;
      step();
   endtask

   task automatic rd(input int dut, input logic [31:0] a, input logic [31:0] e, input string name);
      ce = 1'b1; we = 1'b0; addr = a; sel = 4'hF;
      expect_v(dut, 0, e, name);
      step();
   endtask

   initial begin
      rst = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; sel = '0; wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check_now({31'b0, irq1}, 32'h0, "rst_irq1_now");
      check_now({31'b0, irq4}, 32'h0, "rst_irq4_now");
      check_now({31'b0, err1}, 32'h0, "rst_err1_now");
      check_now({31'b0, err4}, 32'h0, "rst_err4_now");
      check_now(rdata1, 32'h0, "rst_data1_now");
      check_now(rdata4, 32'h0, "rst_data4_now");
      expect_v(1, 1, 0, "rst_irq1");
      expect_v(1, 2, 0, "rst_err1");
      expect_v(4, 0, 0, "rst_data4");
      rst = 1'b0;
      idle(1);
      expect_v(1, 0, 0, "idle_data1");
      rd(1, T_MLO, 32'h0, "rst_mtime_lo");
      rd(1, T_CLO, 32'hFFFF_FFFF, "rst_cmp_lo");
      rd(4, T_CHI, 32'hFFFF_FFFF, "rst_cmp_hi4");
      rd(4, T_CTRL, 32'h0, "rst_ctrl4");

      // RAM byte lanes
      wr(32'h10, 32'h1122_3344, 4'hF);
      rd(1, 32'h10, 32'h1122_3344, "ram_word");
      wr(32'h10, 32'hAABB_CCDD, 4'b0101);
      rd(1, 32'h10, 32'h11BB_33DD, "ram_lanes");
      expect_v(1, 0, 0, "wr_cycle_data");
      wr(32'h10, 32'h0, 4'h0);
      rd(4, 32'h10, 32'h11BB_33DD, "ram_sel0");
      addr = 32'h10;
      expect_v(1, 0, 0, "ce0_data");
      idle(1);

      // prescaler on the PRESCALE=4 instance
      wr(T_CTRL, 32'h1, 4'hF);
      idle(40);
      rd(4, T_MLO, 32'd10, "psc4_count");
      wr(T_CTRL, 32'h0, 4'hF);
      rd(4, T_MLO, 32'd10, "psc4_frozen0");
      idle(20);
      rd(4, T_MLO, 32'd10, "psc4_frozen20");

      // compare interrupt
      wr(T_MLO, 32'h0, 4'hF);
      wr(T_MHI, 32'h0, 4'hF);
      wr(T_CHI, 32'h0, 4'hF);
      wr(T_CLO, 32'h8, 4'hF);
      expect_v(1, 1, 0, "irq_disabled");
      wr(T_CTRL, 32'h1, 4'hF);
      idle(7);
      expect_v(1, 1, 0, "irq_at7");
      idle(1);
      expect_v(1, 1, 1, "irq_at8");
      rd(1, T_MLO, 32'd8, "mtime_at8");
      expect_v(1, 1, 1, "irq_held");
      wr(T_CLO, 32'h100, 4'hF);
      expect_v(1, 1, 0, "irq_drop");

      // carry into the high word
      wr(T_CTRL, 32'h0, 4'hF);
      wr(T_MHI, 32'h0, 4'hF);
      wr(T_MLO, 32'hFFFF_FFFF, 4'hF);
      wr(T_CTRL, 32'h1, 4'hF);
      wr(T_CTRL, 32'h0, 4'hF);
      rd(1, T_MHI, 32'h1, "carry_hi");
      rd(1, T_MLO, 32'h0, "carry_lo");
      wr(T_MHI, 32'h0, 4'hF);
      wr(T_MLO, 32'hFFFF_FFFF, 4'hF);
      wr(T_CTRL, 32'h1, 4'hF);
      wr(T_MLO, 32'h5, 4'hF);
      rd(1, T_MLO, 32'h5, "tickwr_lo");
      rd(1, T_MHI, 32'h1, "tickwr_hi");
      wr(T_CTRL, 32'h0, 4'hF);
      wr(T_MHI, 32'h55, 4'b0011);
      rd(1, T_MHI, 32'h1, "partial_tmr_wr");

      // reset in the middle of a RAM write while counting
      wr(32'h20, 32'hCAFE_F00D, 4'hF);
      wr(T_CLO, 32'h0, 4'hF);
      wr(T_CTRL, 32'h1, 4'hF);
      expect_v(1, 1, 1, "irq_before_rst");
      ce = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h1234_5678; sel = 4'hF;
      rst = 1'b1;
      step();
      rst = 1'b0;
      expect_v(1, 1, 0, "rst_mid_irq");
      rd(1, 32'h20, 32'hCAFE_F00D, "rst_mid_ram");
      rd(1, T_MLO, 32'h0, "rst_mid_mtime_lo");
      rd(4, T_MHI, 32'h0, "rst_mid_mtime_hi4");
      rd(1, T_CTRL, 32'h0, "rst_mid_en");
      rd(1, T_CLO, 32'hFFFF_FFFF, "rst_mid_cmp");

      // unmapped and misaligned accesses
      expect_v(1, 2, 0, "err_before");
      rd(1, 32'h8000_0000, 32'h0, "unmapped_rd");
      expect_v(1, 2, EXP_ERR, "err_set");
      expect_v(4, 2, EXP_ERR, "err_set4");
      idle(3);
      expect_v(1, 2, EXP_ERR, "err_held");
      rd(1, 32'h4000_0014, 32'h0, "tmr_hole_rd");
      rd(1, 32'h11, EXP_MIS, "misaligned_rd");

      idle(2);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
